// File: rtl/control_alu_mdu.sv
// EX-stage ALU control decoder plus an iterative multiply/divide unit with HI/LO registers.
// Stalls the front of the pipeline while the MDU is busy and an MDU instruction is waiting.
module control_alu_mdu #(
    parameter int NBITS         = 32,
    parameter int NBITS_FUNCT   = 6,
    parameter int NBITS_CONTROL = 2,
    parameter int ALUOP         = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_valid,
    input  logic [NBITS_FUNCT-1:0]   i_Funct,
    input  logic [NBITS_FUNCT-1:0]   i_Opcode,
    input  logic [NBITS_CONTROL-1:0] i_ALUOp,
    input  logic [NBITS-1:0]         i_RS,
    input  logic [NBITS-1:0]         i_RT,
    output logic [ALUOP-1:0]         o_ALUOp,
    output logic                     o_MDSel,
    output logic [NBITS-1:0]         o_MDResult,
    output logic                     o_Stall,
    output logic                     o_Busy
);

    localparam int CNTW = $clog2(NBITS);

    localparam logic [ALUOP-1:0] OP_AND  = 4'b0000;
    localparam logic [ALUOP-1:0] OP_OR   = 4'b0001;
    localparam logic [ALUOP-1:0] OP_ADD  = 4'b0010;
    localparam logic [ALUOP-1:0] OP_XOR  = 4'b0011;
    localparam logic [ALUOP-1:0] OP_SUB  = 4'b0110;
    localparam logic [ALUOP-1:0] OP_SLT  = 4'b0111;
    localparam logic [ALUOP-1:0] OP_SLL  = 4'b1000;
    localparam logic [ALUOP-1:0] OP_SRL  = 4'b1001;
    localparam logic [ALUOP-1:0] OP_SRA  = 4'b1010;
    localparam logic [ALUOP-1:0] OP_LUI  = 4'b1011;
    localparam logic [ALUOP-1:0] OP_NOR  = 4'b1100;
    localparam logic [ALUOP-1:0] OP_SLTU = 4'b1101;
    localparam logic [ALUOP-1:0] OP_ILL  = 4'b1111;

    localparam logic [NBITS_FUNCT-1:0] F_MFHI  = 6'b010000;
    localparam logic [NBITS_FUNCT-1:0] F_MTHI  = 6'b010001;
    localparam logic [NBITS_FUNCT-1:0] F_MFLO  = 6'b010010;
    localparam logic [NBITS_FUNCT-1:0] F_MTLO  = 6'b010011;
    localparam logic [NBITS_FUNCT-1:0] F_MULT  = 6'b011000;
    localparam logic [NBITS_FUNCT-1:0] F_MULTU = 6'b011001;
    localparam logic [NBITS_FUNCT-1:0] F_DIV   = 6'b011010;
    localparam logic [NBITS_FUNCT-1:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state_q, state_d;
    logic [NBITS-1:0]   hi_q, hi_d;
    logic [NBITS-1:0]   lo_q, lo_d;
    logic [NBITS-1:0]   opb_q, opb_d;
    logic [2*NBITS-1:0] work_q, work_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               dz_q, dz_d;
    logic               isdiv_q, isdiv_d;

    logic               is_mdu;
    logic               accept;
    logic               signed_op;
    logic               rs_neg, rt_neg;
    logic [NBITS-1:0]   rs_mag, rt_mag;
    logic [NBITS:0]     mul_sum;
    logic [NBITS:0]     div_shift;
    logic [NBITS+1:0]   div_diff;
    logic [2*NBITS-1:0] fix_prod;
    logic [NBITS-1:0]   fix_quot, fix_rem;
    logic               last_step;

    always_comb begin
        o_ALUOp = OP_ILL;
        case (i_ALUOp)
            2'b00: o_ALUOp = OP_ADD;
            2'b01: o_ALUOp = OP_SUB;
            2'b10: begin
                case (i_Funct)
                    6'b100000, 6'b100001: o_ALUOp = OP_ADD;
                    6'b100010, 6'b100011: o_ALUOp = OP_SUB;
                    6'b100100:            o_ALUOp = OP_AND;
                    6'b100101:            o_ALUOp = OP_OR;
                    6'b100110:            o_ALUOp = OP_XOR;
                    6'b100111:            o_ALUOp = OP_NOR;
                    6'b101010:            o_ALUOp = OP_SLT;
                    6'b101011:            o_ALUOp = OP_SLTU;
                    6'b000000:            o_ALUOp = OP_SLL;
                    6'b000010:            o_ALUOp = OP_SRL;
                    6'b000011:            o_ALUOp = OP_SRA;
                    F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                    F_MULT, F_MULTU, F_DIV, F_DIVU: o_ALUOp = OP_ADD;
                    default:              o_ALUOp = OP_ILL;
                endcase
            end
            default: begin
                case (i_Opcode)
                    6'b001000, 6'b001001: o_ALUOp = OP_ADD;
                    6'b001010:            o_ALUOp = OP_SLT;
                    6'b001011:            o_ALUOp = OP_SLTU;
                    6'b001100:            o_ALUOp = OP_AND;
                    6'b001101:            o_ALUOp = OP_OR;
                    6'b001110:            o_ALUOp = OP_XOR;
                    6'b001111:            o_ALUOp = OP_LUI;
                    default:              o_ALUOp = OP_ILL;
                endcase
            end
        endcase
    end

    always_comb begin
        is_mdu = 1'b0;
        if (i_ALUOp == 2'b10) begin
            case (i_Funct)
                F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                F_MULT, F_MULTU, F_DIV, F_DIVU: is_mdu = 1'b1;
                default:                        is_mdu = 1'b0;
            endcase
        end
    end

    assign o_Busy  = (state_q != IDLE);
    assign accept  = i_valid & is_mdu & ~o_Busy;
    assign o_Stall = i_valid & is_mdu & o_Busy;

    assign o_MDSel    = accept & ((i_Funct == F_MFHI) | (i_Funct == F_MFLO));
    assign o_MDResult = !o_MDSel ? '0 : ((i_Funct == F_MFHI) ? hi_q : lo_q);

    // Operands are iterated as magnitudes; signs are reapplied in FIX.
    assign signed_op = (i_Funct == F_MULT) | (i_Funct == F_DIV);
    assign rs_neg    = signed_op & i_RS[NBITS-1];
    assign rt_neg    = signed_op & i_RT[NBITS-1];
    assign rs_mag    = rs_neg ? -i_RS : i_RS;
    assign rt_mag    = rt_neg ? -i_RT : i_RT;

    assign mul_sum   = {1'b0, work_q[2*NBITS-1:NBITS]} + (work_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {work_q[2*NBITS-1:NBITS], work_q[NBITS-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
    assign last_step = (cnt_q == CNTW'(NBITS-1));

    assign fix_prod = negq_q ? -work_q : work_q;
    assign fix_quot = dz_q ? '1 : (negq_q ? -work_q[NBITS-1:0] : work_q[NBITS-1:0]);
    assign fix_rem  = negr_q ? -work_q[2*NBITS-1:NBITS] : work_q[2*NBITS-1:NBITS];

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        isdiv_d = isdiv_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (i_Funct)
                        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                            work_d  = {{NBITS{1'b0}}, rs_mag};
                            opb_d   = rt_mag;
                            cnt_d   = '0;
                            negq_d  = rs_neg ^ rt_neg;
                            negr_d  = rs_neg;
                            dz_d    = (i_RT == '0);
                            isdiv_d = (i_Funct == F_DIV) | (i_Funct == F_DIVU);
                            state_d = isdiv_d ? DIV : MUL;
                        end
                        F_MTHI:  hi_d = i_RS;
                        F_MTLO:  lo_d = i_RS;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                work_d = {mul_sum, work_q[NBITS-1:1]};
                cnt_d  = cnt_q + 1'b1;
                if (last_step) state_d = FIX;
            end
            DIV: begin
                // Restoring step: keep the difference only if it did not borrow.
                if (!div_diff[NBITS+1])
                    work_d = {div_diff[NBITS-1:0], work_q[NBITS-2:0], 1'b1};
                else
                    work_d = {div_shift[NBITS-1:0], work_q[NBITS-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (last_step) state_d = FIX;
            end
            default: begin
                if (isdiv_q) begin
                    hi_d = fix_rem;
                    lo_d = fix_quot;
                end else begin
                    hi_d = fix_prod[2*NBITS-1:NBITS];
                    lo_d = fix_prod[NBITS-1:0];
                end
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            isdiv_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            isdiv_q <= isdiv_d;
        end
    end

endmodule

// File: tb/tb_control_alu_mdu.sv
// Directed bench for control_alu_mdu: decode table, multiply/divide results,
// latency, stall behaviour and mid-operation reset.
module tb_control_alu_mdu;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic [5:0]  i_Funct;
    logic [5:0]  i_Opcode;
    logic [1:0]  i_ALUOp;
    logic [31:0] i_RS;
    logic [31:0] i_RT;
    logic [3:0]  o_ALUOp;
    logic        o_MDSel;
    logic [31:0] o_MDResult;
    logic        o_Stall;
    logic        o_Busy;

    int numChecks = 0;
    int numFails  = 0;

    localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010;
    localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;

    // {ALUOp, funct/opcode, expected code}
    logic [11:0] decVec [27] = '{
        {2'b00, 6'b000000, 4'b0010}, {2'b01, 6'b000000, 4'b0110},
        {2'b10, 6'b100000, 4'b0010}, {2'b10, 6'b100001, 4'b0010},
        {2'b10, 6'b100010, 4'b0110}, {2'b10, 6'b100011, 4'b0110},
        {2'b10, 6'b100100, 4'b0000}, {2'b10, 6'b100101, 4'b0001},
        {2'b10, 6'b100110, 4'b0011}, {2'b10, 6'b100111, 4'b1100},
        {2'b10, 6'b101010, 4'b0111}, {2'b10, 6'b101011, 4'b1101},
        {2'b10, 6'b000000, 4'b1000}, {2'b10, 6'b000010, 4'b1001},
        {2'b10, 6'b000011, 4'b1010}, {2'b10, 6'b111111, 4'b1111},
        {2'b10, 6'b011000, 4'b0010}, {2'b11, 6'b001000, 4'b0010},
        {2'b11, 6'b001001, 4'b0010}, {2'b11, 6'b001010, 4'b0111},
        {2'b11, 6'b001011, 4'b1101}, {2'b11, 6'b001100, 4'b0000},
        {2'b11, 6'b001101, 4'b0001}, {2'b11, 6'b001110, 4'b0011},
        {2'b11, 6'b001111, 4'b1011}, {2'b11, 6'b000010, 4'b1111},
        {2'b10, 6'b010010, 4'b0010}
    };

    control_alu_mdu dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .i_Funct    (i_Funct),
        .i_Opcode   (i_Opcode),
        .i_ALUOp    (i_ALUOp),
        .i_RS       (i_RS),
        .i_RT       (i_RT),
        .o_ALUOp    (o_ALUOp),
        .o_MDSel    (o_MDSel),
        .o_MDResult (o_MDResult),
        .o_Stall    (o_Stall),
        .o_Busy     (o_Busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] aluop, input logic [5:0] funct,
                                 input logic [31:0] rs, input logic [31:0] rt);
        i_valid  = valid;
        i_ALUOp  = aluop;
        i_Funct  = funct;
        i_Opcode = funct;
        i_RS     = rs;
        i_RT     = rt;
        #1;
    endtask

    // Issue a long MDU op, then count cycles with o_Busy high (bounded).
    task automatic runOp(input logic [5:0] funct, input logic [31:0] rs, input logic [31:0] rt,
                         output int busyCycles);
        applyStimulus(1'b1, 2'b10, funct, rs, rt);
        tick();
        applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        busyCycles = 0;
        while (o_Busy && busyCycles < 100) begin
            busyCycles++;
            tick();
        end
    endtask

    task automatic readMd(input string tag, input logic [5:0] funct, input logic [31:0] exp);
        applyStimulus(1'b1, 2'b10, funct, 32'd0, 32'd0);
        checkOutput({tag, "_sel"}, {31'd0, o_MDSel}, 32'd1);
        checkOutput(tag, o_MDResult, exp);
        tick();
        applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    endtask

    initial begin
        int busy;
        int stallCycles;
        logic [11:0] v;

        i_reset = 1'b1;
        applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        tick();
        tick();
        i_reset = 1'b0;
        checkOutput("reset_busy", {31'd0, o_Busy}, 32'd0);
        readMd("reset_hi", MFHI, 32'd0);
        readMd("reset_lo", MFLO, 32'd0);

        for (int i = 0; i < 27; i++) begin
            v = decVec[i];
            applyStimulus(1'b0, v[11:10], v[9:4], 32'd0, 32'd0);
            checkOutput($sformatf("decode_%0d", i), {28'd0, o_ALUOp}, {28'd0, v[3:0]});
        end

        applyStimulus(1'b0, 2'b10, MFHI, 32'd0, 32'd0);
        checkOutput("mfhi_invalid_sel", {31'd0, o_MDSel}, 32'd0);
        checkOutput("mfhi_invalid_res", o_MDResult, 32'd0);

        runOp(MULT, 32'hFFFFFFFD, 32'd5, busy);
        checkOutput("mult_busy", busy, 33);
        readMd("mult_lo", MFLO, 32'hFFFFFFF1);
        readMd("mult_hi", MFHI, 32'hFFFFFFFF);

        runOp(MULTU, 32'hFFFFFFFD, 32'd5, busy);
        readMd("multu_lo", MFLO, 32'hFFFFFFF1);
        readMd("multu_hi", MFHI, 32'h00000004);

        runOp(DIVU, 32'd7, 32'd2, busy);
        checkOutput("divu_busy", busy, 33);
        readMd("divu_lo", MFLO, 32'd3);
        readMd("divu_hi", MFHI, 32'd1);

        runOp(DIV, 32'hFFFFFFF9, 32'd2, busy);
        readMd("div_lo", MFLO, 32'hFFFFFFFD);
        readMd("div_hi", MFHI, 32'hFFFFFFFF);

        runOp(DIV, 32'h80000000, 32'hFFFFFFFF, busy);
        readMd("divovf_lo", MFLO, 32'h80000000);
        readMd("divovf_hi", MFHI, 32'd0);

        runOp(DIVU, 32'h1234, 32'd0, busy);
        checkOutput("divz_busy", busy, 33);
        readMd("divz_lo", MFLO, 32'hFFFFFFFF);
        readMd("divz_hi", MFHI, 32'h1234);

        runOp(DIV, 32'hFFFFFFF0, 32'd0, busy);
        readMd("sdivz_lo", MFLO, 32'hFFFFFFFF);
        readMd("sdivz_hi", MFHI, 32'hFFFFFFF0);

        // MULT, one ADD while busy, then an MFLO that must wait for the result.
        applyStimulus(1'b1, 2'b10, MULT, 32'd6, 32'd7);
        tick();
        applyStimulus(1'b1, 2'b10, 6'b100000, 32'd0, 32'd0);
        checkOutput("add_busy_stall", {31'd0, o_Stall}, 32'd0);
        checkOutput("add_busy_aluop", {28'd0, o_ALUOp}, 32'h2);
        checkOutput("add_busy_busy", {31'd0, o_Busy}, 32'd1);
        tick();
        applyStimulus(1'b1, 2'b10, MFLO, 32'd0, 32'd0);
        stallCycles = 0;
        while (o_Stall && stallCycles < 100) begin
            stallCycles++;
            checkOutput("stall_sel", {31'd0, o_MDSel}, 32'd0);
            tick();
            #1;
        end
        checkOutput("stall_cycles", stallCycles, 32);
        checkOutput("stall_mflo_sel", {31'd0, o_MDSel}, 32'd1);
        checkOutput("stall_mflo_res", o_MDResult, 32'd42);
        tick();
        applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);

        applyStimulus(1'b1, 2'b10, MTHI, 32'hA5A5A5A5, 32'd0);
        tick();
        readMd("mthi_hi", MFHI, 32'hA5A5A5A5);
        readMd("mthi_lo", MFLO, 32'd42);

        // Reset lands in the tenth busy cycle of a DIV.
        applyStimulus(1'b1, 2'b10, DIV, 32'd100, 32'd7);
        tick();
        applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        for (int i = 0; i < 9; i++) tick();
        checkOutput("prereset_busy", {31'd0, o_Busy}, 32'd1);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        checkOutput("abort_busy", {31'd0, o_Busy}, 32'd0);
        readMd("abort_hi", MFHI, 32'd0);
        readMd("abort_lo", MFLO, 32'd0);

        runOp(MULTU, 32'd3, 32'd4, busy);
        checkOutput("multu34_busy", busy, 33);
        readMd("multu34_lo", MFLO, 32'd12);
        readMd("multu34_hi", MFHI, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
